ds_cic_demod: RTL
=================

Name: ds_cic_demod

Overview:
- Receive-side counterpart of the first-order delta-sigma modulator path.
- Takes a 1-bit delta-sigma bitstream and recovers multi-bit samples using a CIC (sinc^N) decimation filter. Output samples are unsigned offset-binary, matching the NCO/modulator sample format.
- Used for loopback verification of the DAC chain, and as an ADC front end with an external comparator and RC network.

Parameters:
- CIC_ORDER, 3, number of integrator and comb stages (N); legal range 1..5.
- DEC_LOG2, 6, log2 of the decimation ratio (R = 2^DEC_LOG2); legal range 2..10.
- OUT_W, 16, output sample width. Must satisfy OUT_W <= CIC_ORDER*DEC_LOG2.
- Localparam ACC_W = CIC_ORDER*DEC_LOG2 + 1, the internal integrator/comb width.

Ports:
- clk, input, 1, single clock (48 MHz HFOSC domain).
- rst_n, input, 1, asynchronous active-low reset.
- ds_din, input, 1, delta-sigma bitstream; may be asynchronous (pin).
- smp_en, input, 1, sample strobe; one input bit is consumed per cycle with smp_en=1. Tie high to consume one bit per clock.
- dmod_out, output, OUT_W, decimated sample, unsigned.
- dmod_valid, output, 1, one-cycle pulse when dmod_out updates.
- dmod_settled, output, 1, sticky; high once filter history is full.

Behaviour:
- Reset (async assert, sync deassert assumed from the board):
  - All of the following clear to 0: sync flops, integrators, comb delays, decimation counter, output-count counter, dmod_out, dmod_valid, dmod_settled.
  - Reset asserted mid-operation aborts the current frame. No partial output is produced.
- Input path:
  - ds_din passes through a 2-flop synchronizer; bit b = sync stage 2.
  - Mapping: 1 -> +1, 0 -> 0. No signed mapping.
- Integrators:
  - On each cycle with smp_en=1, the chain updates: I1 += b, Ik += I(k-1), all registered, ACC_W bits each.
  - Modulo-2^ACC_W wrap-around is required and legal. No saturation inside the integrators.
  - With smp_en=0, all integrators hold.
- Decimation counter:
  - DEC_LOG2 bits; increments on smp_en and wraps from R-1 to 0.
  - The smp_en cycle where the counter is at R-1 sets an internal dec_tick for the next cycle.
- Comb section (evaluated only in the dec_tick cycle):
  - C0 = I_N. Ck = C(k-1) - D_k, where D_k holds the previous C(k-1).
  - Each D_k updates to C(k-1) in the dec_tick cycle.
  - All arithmetic is ACC_W-bit modulo; the final C_N is exact in [0, R^N].
- Output scaling:
  - S = C_N >> (CIC_ORDER*DEC_LOG2 - OUT_W).
  - If C_N == R^N (all-ones input), dmod_out = 2^OUT_W - 1 (saturate). Otherwise dmod_out = S[OUT_W-1:0].
- Output timing:
  - dmod_out is registered and updates in the cycle after dec_tick.
  - dmod_valid is high for exactly that one cycle.
  - Valid period is exactly R smp_en cycles; with smp_en tied high, that is one pulse every R clocks.
  - dmod_out holds between pulses.
- Settled flag:
  - A 3-bit output counter increments on each dmod_valid, saturating.
  - dmod_settled rises in the same cycle as the (CIC_ORDER+1)th dmod_valid and stays high until reset.
  - Outputs before dmod_settled carry transient values and are not checked against steady state.
- smp_en low during the dec_tick cycle does not suppress the comb/output update; the tick is already committed.

Test Plan:
- Constant ds_din=1, smp_en=1, defaults -> dmod_valid every 64 clocks; after dmod_settled, dmod_out=0xFFFF (saturated, C_N=262144).
- Constant ds_din=0 -> every settled output is 0x0000; integrators remain 0.
- ds_din alternating 1,0 every clock -> settled dmod_out=0x8000 exactly (C_N=131072). The same result holds for any phase.
- smp_en toggled 1,0,1,0 with ds_din=1 -> dmod_valid period 128 clocks; settled value 0xFFFF. Integrators must not change during smp_en=0 cycles.
- Loopback from SIN_NCO plus modulator at a mid-scale DC word 0x4000 -> settled dmod_out within ±2 LSB of 0x4000.
- Assert rst_n low for 1 cycle mid-frame after settling -> all outputs read 0 immediately (async). dmod_settled re-rises exactly at the 4th subsequent dmod_valid; the first valid occurs 64 smp_en cycles after reset release.

Source files
------------

// File: rtl/ds_cic_if.sv
// ds_cic_if: bitstream input and decimated sample output bundle for ds_cic_demod
//   ds_din       delta-sigma bitstream (may be asynchronous)
//   smp_en       consume one bitstream bit this cycle
//   dmod_out     decimated unsigned sample
//   dmod_valid   one-cycle pulse when dmod_out updates
//   dmod_settled sticky, high once filter history is full
interface ds_cic_if #(parameter int OUT_W = 16);
  logic ds_din;
  logic smp_en;
  logic [OUT_W-1:0] dmod_out;
  logic dmod_valid;
  logic dmod_settled;
  modport master(output ds_din, smp_en, input dmod_out, dmod_valid, dmod_settled);
  modport slave(input ds_din, smp_en, output dmod_out, dmod_valid, dmod_settled);
endinterface

// File: rtl/ds_cic_demod.sv
// ds_cic_demod: sinc^N CIC decimator turning a 1-bit delta-sigma stream into unsigned samples
//   clk   single clock
//   rst_n asynchronous active-low reset
//   bus   ds_cic_if slave: ds_din/smp_en in, dmod_out/dmod_valid/dmod_settled out
module ds_cic_demod #(
  parameter int CIC_ORDER = 3,
  parameter int DEC_LOG2 = 6,
  parameter int OUT_W = 16
) (
  input logic clk,
  input logic rst_n,
  ds_cic_if.slave bus
);
  localparam int ACC_W = CIC_ORDER * DEC_LOG2 + 1;
  localparam int SH = CIC_ORDER * DEC_LOG2 - OUT_W;
  // R^N: the only comb result that does not fit OUT_W after scaling
  localparam logic [ACC_W-1:0] FULL = ACC_W'(1) << (CIC_ORDER * DEC_LOG2);
  logic s1, s2, dec_tick;
  logic [DEC_LOG2-1:0] cnt;
  logic [2:0] out_cnt;
  logic [ACC_W-1:0] integ [CIC_ORDER];
  logic [ACC_W-1:0] c_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      dec_tick <= 1'b0;
      for (int k = 0; k < CIC_ORDER; k++) integ[k] <= '0;
    end else begin
      s1 <= bus.ds_din;
      s2 <= s1;
      dec_tick <= bus.smp_en && (&cnt);
      if (bus.smp_en) begin
        cnt <= cnt + 1'b1;
        integ[0] <= integ[0] + ACC_W'(s2);
        for (int k = 1; k < CIC_ORDER; k++) integ[k] <= integ[k] + integ[k-1];
      end
    end
  end
  genvar k;
  for (k = 0; k < CIC_ORDER; k++) begin : g_comb
    logic [ACC_W-1:0] cin, cv, dly;
    if (k == 0) begin : g_first
      assign cin = integ[CIC_ORDER-1];
    end else begin : g_next
      assign cin = g_comb[k-1].cv;
    end
    assign cv = cin - dly;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dly <= '0;
      else if (dec_tick) dly <= cin;
    end
  end
  assign c_n = g_comb[CIC_ORDER-1].cv;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dmod_out <= '0;
      bus.dmod_valid <= 1'b0;
      bus.dmod_settled <= 1'b0;
      out_cnt <= '0;
    end else begin
      bus.dmod_valid <= dec_tick;
      if (dec_tick) begin
        bus.dmod_out <= (c_n == FULL) ? '1 : OUT_W'(c_n >> SH);
        out_cnt <= (&out_cnt) ? out_cnt : out_cnt + 3'd1;
        // out_cnt still holds the count of earlier pulses, so this pulse is the (N+1)th
        bus.dmod_settled <= bus.dmod_settled | (32'(out_cnt) >= CIC_ORDER);
      end
    end
  end
endmodule
